if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction buffer between the fetch stage (pc_reg + rom) and the decode stage.
//  - Captures each fetched {pc, inst} pair into a small FIFO.
//  - Presents the oldest entry to decode.
//  - Valid/ready handshakes on both sides let decode stall without losing fetched words.
//  - flush_i (branch/jump redirect) discards every buffered entry.
// PARAMETERS
//  AW     32  width of instruction address (pc)
//  IW     32  width of instruction word
//  DEPTH  2   number of entries; power of two, >= 2
// PORTS
//  clk           in   1         system clock, all state on rising edge
//  rst           in   1         synchronous reset, active-high
//  flush_i       in   1         discard all entries (redirect)
//  if_valid_i    in   1         fetch presents a valid {pc, inst}
//  if_pc_i       in   AW        pc of the presented instruction
//  if_inst_i     in   IW        instruction word from rom
//  if_ready_o    out  1         queue can accept an entry this cycle
//  id_valid_o    out  1         head entry is valid
//  id_pc_o       out  AW        pc of the head entry
//  id_inst_o     out  IW        instruction of the head entry
//  id_ready_i    in   1         decode consumes the head entry this cycle
//  count_o       out  log2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - wr_ptr, rd_ptr and count are cleared to 0.
//  - Storage contents are don't-care.
//  - While rst=1: if_ready_o=0, id_valid_o=0.
//  - First accept is possible in the cycle after rst deasserts.
//  Handshake rules:
//  - push = if_valid_i & if_ready_o & ~flush_i.
//  - pop  = id_valid_o & id_ready_i & ~flush_i.
//  Output decode:
//  - if_ready_o = ~rst & (count < DEPTH). Combinational from registered count only; no dependence on id_ready_i.
//  - id_valid_o = (count != 0).
//  - id_pc_o / id_inst_o = mem[rd_ptr] when valid.
//  - When empty: id_inst_o = 32'h0000_0013 (NOP, addi x0,x0,0) and id_pc_o = 0.
//  Latency: a word pushed at edge N is visible on id_* after edge N. There is no combinational bypass from if_* to id_*.
//  Simultaneous push and pop (0 < count < DEPTH): both take effect, count unchanged.
//  Full (count == DEPTH):
//  - if_ready_o = 0, even if a pop occurs that cycle.
//  - The freed slot becomes available the following cycle.
//  Empty (count == 0): a pop is impossible; id_ready_i is ignored.
//  Pointer wrap-around: wr_ptr/rd_ptr are log2(DEPTH) bits and wrap naturally modulo DEPTH.
//  flush_i = 1:
//  - Next cycle: count = 0 and rd_ptr = wr_ptr.
//  - That cycle's push and pop are both suppressed, so the in-flight fetch word is dropped.
//  - id_valid_o = 0 in the cycle after the flush.
//  - Priority: rst > flush_i > push/pop.
//  Reset mid-operation: all entries are lost, identical to the reset above.
//  count_o: the registered occupancy, 0..DEPTH.
// TESTING
//  1. Reset: rst=1 for 2 cycles, then 0 -> during reset if_ready_o=0, id_valid_o=0, id_inst_o=0x00000013; after reset if_ready_o=1, count_o=0.
//  2. Streaming: if_valid_i=1 with pc 0x0,0x4,0x8, inst 0x00100093,0x00200113,0x00300193; id_ready_i=1 -> id_* shows the same sequence, one cycle later; count_o stays 1.
//  3. Stall/full: id_ready_i=0, push pc 0x0 then 0x4 -> count_o=2, if_ready_o=0; a third word is held off; raise id_ready_i -> pops 0x0, then 0x4, with no loss or duplication.
//  4. Flush: queue holds pc 0x10,0x14; assert flush_i together with a push of pc 0x18 -> next cycle count_o=0, id_valid_o=0; 0x18 never appears on id_*.
//  5. Wrap: push/pop 7 words (pc 0x0..0x18) with random id_ready_i -> order is preserved across pointer wrap; the scoreboard matches all 7.
//  6. Reset mid-operation: count_o=2, assert rst for 1 cycle -> count_o=0, id_valid_o=0; the next push of pc 0x40 is the first word out.

Source files
------------

// File: rtl/if_id_queue.sv
// Instruction buffer between fetch (pc_reg + rom) and decode: a DEPTH-entry FIFO of {pc, inst} pairs.
// Latency: a word accepted at edge N is presented on id_* after edge N; there is no if_* -> id_* bypass.
// Backpressure: if_ready_o drops when full and depends only on registered occupancy; decode stalls by holding id_ready_i low.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush_i         redirect: drop every buffered entry and the word offered in the same cycle
//   if_valid_i      fetch offers {if_pc_i, if_inst_i}; accepted when if_ready_o is high
//   if_ready_o      queue has a free slot this cycle
//   id_valid_o      head entry {id_pc_o, id_inst_o} is valid; NOP/pc 0 are shown when empty
//   id_ready_i      decode consumes the head entry this cycle
//   count_o         registered occupancy, 0..DEPTH

module if_id_queue #(
    parameter int AW    = 32,
    parameter int IW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    input  logic [AW-1:0]            if_pc_i,
    input  logic [IW-1:0]            if_inst_i,
    output logic                     if_ready_o,
    output logic                     id_valid_o,
    output logic [AW-1:0]            id_pc_o,
    output logic [IW-1:0]            id_inst_o,
    input  logic                     id_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // addi x0, x0, 0 -- what decode sees whenever nothing is buffered
    localparam logic [IW-1:0] NOP_INST = IW'(32'h0000_0013);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [IW-1:0] inst_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Ready comes from registered state only, so a pop in a full cycle does
    // not open the slot until the next cycle; this keeps fetch timing short.
    assign if_ready_o = ~rst & ~full;

    // Gated by rst so the outputs are clean even before the first reset edge
    // has cleared count.
    assign id_valid_o = ~rst & ~empty;

    // A flush suppresses both sides so the in-flight fetch word is dropped
    // and decode does not consume the stale head.
    assign push = if_valid_i & if_ready_o & ~flush_i;
    assign pop  = id_valid_o & id_ready_i & ~flush_i;

    assign id_pc_o   = id_valid_o ? pc_mem[rd_ptr]   : '0;
    assign id_inst_o = id_valid_o ? inst_mem[rd_ptr] : NOP_INST;
    assign count_o   = count;

    // Storage needs no reset: its contents are only visible through rd_ptr
    // when count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= if_pc_i;
            inst_mem[wr_ptr] <= if_inst_i;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            // Realign read to write so the queue is empty without touching wr_ptr.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } entry_t;

    logic                  clk;
    logic                  rst;
    logic                  flush_i;
    logic                  if_valid_i;
    logic [AW-1:0]         if_pc_i;
    logic [IW-1:0]         if_inst_i;
    logic                  if_ready_o;
    logic                  id_valid_o;
    logic [AW-1:0]         id_pc_o;
    logic [IW-1:0]         id_inst_o;
    logic                  id_ready_i;
    logic [$clog2(DEPTH):0] count_o;

    int n_cmp = 0;
    int n_bad = 0;

    entry_t model_q[$];     // reference contents, oldest first
    entry_t got_q[$];       // words actually consumed by decode

    if_id_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_ready_i (id_ready_i),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // addi x(n+1), x0, n+1 for pc = 4*n
    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
        logic [31:0] n;
        n = (pc >> 2) + 1;
        return (n << 20) | ((n & 32'h1f) << 7) | 32'h13;
    endfunction

    // Reference model: a plain queue advanced by the handshake rules.
    always @(posedge clk) begin
        bit m_rdy, m_vld, m_push, m_pop;
        entry_t e;
        m_rdy = !rst && (model_q.size() < DEPTH);
        m_vld = !rst && (model_q.size() != 0);
        if (rst || flush_i) begin
            model_q.delete();
        end else begin
            m_push = if_valid_i && m_rdy;
            m_pop  = m_vld && id_ready_i;
            if (m_pop) void'(model_q.pop_front());
            if (m_push) begin
                e.pc   = if_pc_i;
                e.inst = if_inst_i;
                model_q.push_back(e);
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit e_rdy, e_vld;
        logic [AW-1:0] e_pc;
        logic [IW-1:0] e_inst;
        entry_t e;
        e_rdy  = !rst && (model_q.size() < DEPTH);
        e_vld  = !rst && (model_q.size() != 0);
        e_pc   = e_vld ? model_q[0].pc   : '0;
        e_inst = e_vld ? model_q[0].inst : 32'h0000_0013;
        check("if_ready_o", 64'(if_ready_o), 64'(e_rdy));
        check("id_valid_o", 64'(id_valid_o), 64'(e_vld));
        check("id_pc_o",    64'(id_pc_o),    64'(e_pc));
        check("id_inst_o",  64'(id_inst_o),  64'(e_inst));
        check("count_o",    64'(count_o),    64'(model_q.size()));
        if (id_valid_o && id_ready_i && !flush_i && !rst) begin
            e.pc   = id_pc_o;
            e.inst = id_inst_o;
            got_q.push_back(e);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one word until accepted (bounded); optionally randomise decode readiness.
    task automatic push_word(input logic [AW-1:0] pc, input bit rand_rdy);
        bit accepted;
        bit ready_now;
        accepted   = 1'b0;
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        if_inst_i  = inst_of(pc);
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (rand_rdy) id_ready_i = 1'($urandom_range(0, 1));
            #0;
            ready_now = if_ready_o;
            @(posedge clk);
            #1;
            accepted = ready_now;
        end
        check("push_accept_timeout", 64'(accepted), 64'd1);
        if_valid_i = 1'b0;
    endtask

    task automatic drain();
        id_ready_i = 1'b1;
        for (int i = 0; i < 20 && count_o != 0; i++) cycles(1);
        check("drain_timeout", 64'(count_o), 64'd0);
    endtask

    task automatic expect_got(input string name, input logic [AW-1:0] pcs[$]);
        check({name, "_len"}, 64'(got_q.size()), 64'(pcs.size()));
        for (int i = 0; i < pcs.size() && i < got_q.size(); i++) begin
            check({name, "_pc"},   64'(got_q[i].pc),   64'(pcs[i]));
            check({name, "_inst"}, 64'(got_q[i].inst), 64'(inst_of(pcs[i])));
        end
        got_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        if_pc_i    = '0;
        if_inst_i  = '0;
        id_ready_i = 1'b0;

        // 1. Reset for two cycles
        cycles(1);
        check("rst_if_ready", 64'(if_ready_o), 64'd0);
        check("rst_id_valid", 64'(id_valid_o), 64'd0);
        check("rst_id_inst",  64'(id_inst_o),  64'h13);
        cycles(1);
        rst = 1'b0;
        #1;
        check("post_rst_if_ready", 64'(if_ready_o), 64'd1);
        check("post_rst_count",    64'(count_o),    64'd0);

        // 2. Streaming with decode always ready
        id_ready_i = 1'b1;
        push_word(32'h0, 1'b0);
        check("stream_count0", 64'(count_o), 64'd1);
        check("stream_inst0",  64'(id_inst_o), 64'h0010_0093);
        push_word(32'h4, 1'b0);
        check("stream_count1", 64'(count_o), 64'd1);
        check("stream_inst1",  64'(id_inst_o), 64'h0020_0113);
        push_word(32'h8, 1'b0);
        check("stream_count2", 64'(count_o), 64'd1);
        check("stream_inst2",  64'(id_inst_o), 64'h0030_0193);
        drain();
        expect_got("stream", '{32'h0, 32'h4, 32'h8});

        // 3. Stall until full, hold a third word off, then release
        id_ready_i = 1'b0;
        push_word(32'h0, 1'b0);
        push_word(32'h4, 1'b0);
        check("full_count", 64'(count_o),    64'd2);
        check("full_ready", 64'(if_ready_o), 64'd0);
        if_valid_i = 1'b1;
        if_pc_i    = 32'h8;
        if_inst_i  = inst_of(32'h8);
        cycles(2);
        check("held_count", 64'(count_o), 64'd2);
        id_ready_i = 1'b1;
        push_word(32'h8, 1'b0);
        drain();
        expect_got("stall", '{32'h0, 32'h4, 32'h8});

        // 4. Flush while full, then flush while a push and pop would both fire
        id_ready_i = 1'b0;
        push_word(32'h10, 1'b0);
        push_word(32'h14, 1'b0);
        flush_i    = 1'b1;
        if_valid_i = 1'b1;
        if_pc_i    = 32'h18;
        if_inst_i  = inst_of(32'h18);
        cycles(1);
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        #1;
        check("flush_count", 64'(count_o),    64'd0);
        check("flush_valid", 64'(id_valid_o), 64'd0);
        push_word(32'h20, 1'b0);
        flush_i    = 1'b1;
        if_valid_i = 1'b1;
        if_pc_i    = 32'h24;
        if_inst_i  = inst_of(32'h24);
        id_ready_i = 1'b1;
        cycles(1);
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        #1;
        check("flush2_count", 64'(count_o), 64'd0);
        drain();
        check("flush_nothing_out", 64'(got_q.size()), 64'd0);
        got_q.delete();

        // 5. Seven words across pointer wrap with random decode readiness
        for (int i = 0; i < 7; i++) push_word(AW'(i * 4), 1'b1);
        drain();
        expect_got("wrap", '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14, 32'h18});

        // 6. Reset mid-operation while full
        id_ready_i = 1'b0;
        push_word(32'h30, 1'b0);
        push_word(32'h34, 1'b0);
        check("pre_rst_count", 64'(count_o), 64'd2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        #1;
        check("mid_rst_count", 64'(count_o),    64'd0);
        check("mid_rst_valid", 64'(id_valid_o), 64'd0);
        id_ready_i = 1'b1;
        push_word(32'h40, 1'b0);
        drain();
        expect_got("after_rst", '{32'h40});

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
